// File: rtl/my_mem_par_pkg.sv
// -----------------------------------------------------------------------------
// my_mem_par_pkg
//   Shared types and helpers for the parity-protected memory block.
//   - state_t      : controller state (INIT sweep / RUN).
//   - PW_MAX       : widest payload parity_word() accepts.
//   - parity_word  : returns {even-parity bit, data} for a payload that is
//                    zero-extended to PW_MAX bits. Zero extension does not
//                    change the XOR reduction, so narrower payloads work.
// -----------------------------------------------------------------------------
package my_mem_par_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int PW_MAX = 64;

    function automatic logic [PW_MAX:0] parity_word(input logic [PW_MAX-1:0] data);
        return {^data, data};
    endfunction

endpackage : my_mem_par_pkg

// File: rtl/my_mem_par_array.sv
// -----------------------------------------------------------------------------
// my_mem_par_array
//   Plain single-port synchronous RAM, (2**ADDR_W) x DATA_W.
//   One write port and one registered read port sharing one address.
//
// Ports:
//   clk      in   clock, posedge
//   rst_n    in   synchronous active-low reset (read register only)
//   i_we     in   write enable
//   i_re     in   read enable; o_rdata updates on the same edge
//   i_addr   in   word address
//   i_wdata  in   write word
//   o_rdata  out  registered read word; holds between reads
//
// The storage array itself has no reset; the owner clears it by sweeping.
// The read register is reset so the read port never shows X after reset.
// -----------------------------------------------------------------------------
module my_mem_par_array #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : my_mem_par_array

// File: rtl/my_mem_par.sv
// -----------------------------------------------------------------------------
// my_mem_par
//   Single-port parity-protected synchronous RAM.
//   Each word is stored as {even parity, data}. Every read is parity-checked;
//   parity errors and read+write collisions are counted in a saturating
//   counter. After reset the whole array is swept to zero (busy high) so no
//   read can ever return X.
//
// Optional feature (macro MY_MEM_PAR_ERR_INJECT_EN):
//   Adds input err_inject. When high during a RUN-state write, the stored
//   parity bit is inverted so a later read of that word flags parity_err.
//   Without the macro the port does not exist and stored parity is correct.
//
// Ports:
//   clk          in   clock, posedge
//   rst_n        in   synchronous active-low reset
//   write        in   write strobe
//   read         in   read strobe
//   address      in   word address
//   data_in      in   write payload
//   err_inject   in   (macro only) invert stored parity on this write
//   data_out     out  {parity, data} of the last completed read
//   data_valid   out  1-cycle pulse, data_out holds a fresh read result
//   parity_err   out  1-cycle pulse with data_valid on parity mismatch
//   collision    out  1-cycle pulse, read and write were both asserted
//   busy         out  high during the post-reset zeroing sweep
//   error_count  out  saturating count of parity errors + collisions
//   dbg_state    out  current controller state, for observation only
//
// Handshake: strobes are sampled on every posedge while in RUN; there is no
// back-pressure. A read strobe yields data_valid exactly one cycle later; a
// read+write strobe yields collision one cycle later and touches no memory.
// Strobes are ignored entirely while busy.
// -----------------------------------------------------------------------------
module my_mem_par
    import my_mem_par_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
`ifdef MY_MEM_PAR_ERR_INJECT_EN
    input  logic                  err_inject,
`endif
    output logic [DATA_WIDTH:0]   data_out,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  collision,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  error_count,
    output state_t                dbg_state
);

    localparam int WORD_W = DATA_WIDTH + 1;

    typedef logic [PW_MAX-1:0] pw_in_t;

    // ---------------- state ----------------
    state_t                 r_state;
    state_t                 w_state_next;
    logic [ADDR_WIDTH-1:0]  r_ptr;
    logic                   r_valid;
    logic                   r_collision;
    logic [CNT_WIDTH-1:0]   r_err_cnt;

    // ---------------- array port ----------------
    logic                   w_we;
    logic                   w_re;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [WORD_W-1:0]      w_wdata;
    logic [WORD_W-1:0]      w_rdata;

    // ---------------- parity ----------------
    logic [PW_MAX:0]        w_pw;
    logic                   w_par;
    logic                   w_unused_pw;
    logic                   w_inject;
    logic                   w_par_mismatch;
    logic                   w_rd_only;
    logic                   w_wr_only;
    logic                   w_both;

    assign w_pw        = parity_word(pw_in_t'(data_in));
    assign w_par       = w_pw[PW_MAX];
    // Only the parity bit of the helper result is needed; data comes straight
    // from data_in.
    assign w_unused_pw = ^w_pw[PW_MAX-1:0];

`ifdef MY_MEM_PAR_ERR_INJECT_EN
    assign w_inject = err_inject;
`else
    assign w_inject = 1'b0;
`endif

    assign w_rd_only = read & ~write;
    assign w_wr_only = write & ~read;
    assign w_both    = read & write;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state and array control ----------------
    // Array writes are gated by rst_n so a reset edge never disturbs memory.
    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_re         = 1'b0;
        w_addr       = address;
        w_wdata      = {w_par ^ w_inject, data_in};
        unique case (r_state)
            INIT: begin
                w_we    = rst_n;
                w_addr  = r_ptr;
                w_wdata = '0;
                if (r_ptr == '1) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_we = rst_n & w_wr_only;
                w_re = w_rd_only;
            end
            default: begin
                w_state_next = INIT;
            end
        endcase
    end

    // ---------------- sweep pointer ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (r_state == INIT) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // ---------------- pulses ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_valid     <= (r_state == RUN) & w_rd_only;
            r_collision <= (r_state == RUN) & w_both;
        end
    end

    // ---------------- memory ----------------
    my_mem_par_array #(
        .DATA_W (WORD_W),
        .ADDR_W (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Parity is checked on the registered word, so the error pulse lines up
    // with data_valid without extra pipeline state.
    assign w_par_mismatch = (^w_rdata[DATA_WIDTH-1:0]) != w_rdata[DATA_WIDTH];

    // ---------------- saturating error counter ----------------
    // A read and a collision are mutually exclusive in one cycle, so at most
    // one increment is needed per edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if ((parity_err || collision) && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    // ---------------- outputs ----------------
    assign data_out    = w_rdata;
    assign data_valid  = r_valid;
    assign parity_err  = r_valid & w_par_mismatch;
    assign collision   = r_collision;
    assign busy        = (r_state == INIT);
    assign error_count = r_err_cnt;
    assign dbg_state   = r_state;

endmodule : my_mem_par

// File: tb/tb_my_mem_par.sv
// -----------------------------------------------------------------------------
// tb_my_mem_par
//   Directed self-checking bench for my_mem_par. The counter width is reduced
//   to 3 bits so saturation can be reached in a few collisions.
// -----------------------------------------------------------------------------
module tb_my_mem_par;
  import my_mem_par_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int CW    = 3;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          write;
  logic          read;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
`ifdef MY_MEM_PAR_ERR_INJECT_EN
  logic          err_inject;
`endif
  logic [DW:0]   data_out;
  logic          data_valid;
  logic          parity_err;
  logic          collision;
  logic          busy;
  logic [CW-1:0] error_count;
  state_t        dbg_state;

  my_mem_par #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write       (write),
    .read        (read),
    .address     (address),
    .data_in     (data_in),
`ifdef MY_MEM_PAR_ERR_INJECT_EN
    .err_inject  (err_inject),
`endif
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .collision   (collision),
    .busy        (busy),
    .error_count (error_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write   = 1'b0;
    read    = 1'b0;
    address = '0;
    data_in = '0;
`ifdef MY_MEM_PAR_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write = 1'b1; read = 1'b0; address = a; data_in = d;
    tick();
    idle_inputs();
  endtask

  // Issues a read and checks the result one cycle later.
  task automatic do_read(input string tag, input logic [AW-1:0] a,
                         input logic [DW:0] exp_word, input logic exp_pe);
    read = 1'b1; write = 1'b0; address = a;
    tick();
    idle_inputs();
    check_eq({tag, "_valid"}, 32'(data_valid), 32'd1);
    check_eq({tag, "_data"},  32'(data_out),   32'(exp_word));
    check_eq({tag, "_perr"},  32'(parity_err), 32'(exp_pe));
  endtask

  task automatic do_collision(input logic [AW-1:0] a, input logic [DW-1:0] d);
    read = 1'b1; write = 1'b1; address = a; data_in = d;
    tick();
    idle_inputs();
  endtask

  // Counts edges until busy falls; a run past the bound is a failure.
  task automatic wait_sweep(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 4 * DEPTH);
    check_eq(tag, 32'(n), 32'(DEPTH));
  endtask

  function automatic logic [DW:0] ref_word(input logic [DW-1:0] d);
    return {^d, d};
  endfunction

  // ---------------- stimulus ----------------
  logic [AW-1:0] r_addr [6];
  logic [DW-1:0] r_data [6];
  int            order  [6] = '{3, 0, 5, 1, 4, 2};
  logic [DW:0]   last_word;
  logic [DW:0]   w;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check_eq("rst_data_out",   32'(data_out),    32'd0);
    check_eq("rst_data_valid", 32'(data_valid),  32'd0);
    check_eq("rst_parity_err", 32'(parity_err),  32'd0);
    check_eq("rst_collision",  32'(collision),   32'd0);
    check_eq("rst_err_count",  32'(error_count), 32'd0);
    check_eq("rst_busy",       32'(busy),        32'd1);

    // Strobes during the sweep must be ignored.
    rst_n = 1'b1;
    read  = 1'b1; address = 8'h3C;
    tick();
    check_eq("init_no_valid", 32'(data_valid), 32'd0);
    idle_inputs();
    // One edge already elapsed; remaining sweep length is DEPTH-1.
    begin
      int n;
      n = 1;
      while (busy && n < 4 * DEPTH) begin
        tick();
        n++;
      end
      check_eq("sweep_len", 32'(n), 32'(DEPTH));
    end
    check_eq("state_run", 32'(dbg_state), 32'(RUN));

    do_read("rd_3c", 8'h3C, 9'h000, 1'b0);

    // Directed writes with hand-computed words.
    do_write(8'h10, 8'hA5);
    do_write(8'h11, 8'h01);
    do_write(8'h12, 8'hFF);
    do_read("rd_10", 8'h10, 9'h0A5, 1'b0);
    do_read("rd_11", 8'h11, 9'h101, 1'b0);
    do_read("rd_12", 8'h12, 9'h0FF, 1'b0);
    tick();
    check_eq("valid_drop",  32'(data_valid), 32'd0);
    check_eq("data_hold",   32'(data_out),   32'h0FF);
    check_eq("cnt_clean",   32'(error_count), 32'd0);

    // Read immediately after write to the same address.
    do_write(8'h30, 8'h5A);
    do_read("raw_30", 8'h30, 9'h05A, 1'b0);
    do_write(8'h31, 8'h07);
    do_read("raw_31", 8'h31, 9'h107, 1'b0);

    // Random pairs, distinct addresses in 0x80..0xDF, shuffled readback.
    for (int i = 0; i < 6; i++) begin
      r_addr[i] = 8'(8'h80 + i * 16 + $urandom_range(0, 15));
      r_data[i] = 8'($urandom_range(0, 255));
      do_write(r_addr[i], r_data[i]);
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(ref_word(r_data[order[i]]));
    for (int i = 0; i < 6; i++) begin
      w = exp_q.pop_front();
      do_read($sformatf("rnd%0d", i), r_addr[order[i]], w, 1'b0);
      last_word = w;
    end

    // Collision: no access, one pulse, counted once.
    do_collision(8'h20, 8'h55);
    check_eq("coll_pulse", 32'(collision),  32'd1);
    check_eq("coll_noval", 32'(data_valid), 32'd0);
    check_eq("coll_hold",  32'(data_out),   32'(last_word));
    tick();
    check_eq("coll_once",  32'(collision),   32'd0);
    check_eq("coll_count", 32'(error_count), 32'd1);
    do_read("rd_20", 8'h20, 9'h000, 1'b0);
    check_eq("coll_count2", 32'(error_count), 32'd1);

`ifdef MY_MEM_PAR_ERR_INJECT_EN
    write = 1'b1; address = 8'h40; data_in = 8'h03; err_inject = 1'b1;
    tick();
    idle_inputs();
    do_read("inj_40", 8'h40, 9'h103, 1'b1);
    tick();
    check_eq("inj_count", 32'(error_count), 32'd2);
`endif

    // Saturation: far more events than the 3-bit counter can hold.
    for (int i = 0; i < 9; i++) begin
      do_collision(8'h21, 8'h00);
      tick();
    end
    check_eq("sat_count", 32'(error_count), 32'd7);
    do_read("rd_21", 8'h21, 9'h000, 1'b0);

    // Reset lands on the edge that would have captured a read.
    read = 1'b1; address = 8'h10; rst_n = 1'b0;
    tick();
    idle_inputs();
    check_eq("mid_rst_noval", 32'(data_valid),  32'd0);
    check_eq("mid_rst_busy",  32'(busy),        32'd1);
    check_eq("mid_rst_count", 32'(error_count), 32'd0);
    check_eq("mid_rst_data",  32'(data_out),    32'd0);
    rst_n = 1'b1;
    wait_sweep("resweep_len");
    do_read("rd_10_swept", 8'h10, 9'h000, 1'b0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_my_mem_par
